// File: rtl/cpu_clk_rst_ctrl_if.sv
// Handshake bundle between the clock/reset controller and its host.
// master drives the controls and slave is the controller.
interface cpu_clk_rst_ctrl_if;
    logic [4:0] div_sel_i;
    logic       div_ld_i;
    logic [1:0] mode_i;
    logic       step_i;
    logic       sw_rst_i;
    logic       cpu_tick_o;
    logic       cpu_rst_no;
    logic       rst_done_o;
    logic       heartbeat_o;

    modport master (
        output div_sel_i, div_ld_i, mode_i, step_i, sw_rst_i,
        input  cpu_tick_o, cpu_rst_no, rst_done_o, heartbeat_o
    );

    modport slave (
        input  div_sel_i, div_ld_i, mode_i, step_i, sw_rst_i,
        output cpu_tick_o, cpu_rst_no, rst_done_o, heartbeat_o
    );
endinterface

// File: rtl/cpu_clk_rst_ctrl.sv
// Softcore clock-enable and reset controller: programmable tick divider,
// run/halt/single-step gating, multi-tick core reset and software re-reset.
module cpu_clk_rst_ctrl #(
    parameter int CNT_WIDTH   = 25,
    parameter int DIV_DEFAULT = 14,
    parameter int RST_TICKS   = 4,
    parameter int HB_BIT      = 22
) (
    input  logic                clk_i,
    input  logic                reset_i,
    cpu_clk_rst_ctrl_if.slave   bus
);

    localparam int                   RCW       = $clog2(RST_TICKS + 1);
    localparam logic [4:0]           DIV_MAX   = 5'(CNT_WIDTH - 1);
    localparam logic [4:0]           DIV_RST   = 5'(DIV_DEFAULT);
    localparam logic [RCW-1:0]       RST_LAST  = RCW'(RST_TICKS - 1);
    localparam logic [RCW-1:0]       RCNT_ONE  = RCW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [1:0]           MODE_RUN  = 2'b00;
    localparam logic [1:0]           MODE_STEP = 2'b10;

    typedef enum logic {
        ST_ASSERT = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    state_t               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [4:0]           div_q;
    logic [RCW-1:0]       rst_cnt_q;
    logic                 step_prev_q;
    logic                 step_pend_q;
    logic                 step_pend_d;
    logic                 tick_q;
    logic                 cpu_rst_n_q;
    logic                 rst_done_q;
    logic                 hb_q;

    logic [CNT_WIDTH-1:0] mask_s;
    logic                 raw_tick_s;
    logic                 step_rise_s;
    logic                 step_use_s;
    logic                 sw_rst_run_s;
    logic [4:0]           div_clamp_s;

    // Raw tick detection, divider clamp and single-step bookkeeping.
    always_comb begin
        mask_s = '0;
        for (int i = 0; i < CNT_WIDTH; i++) begin
            mask_s[i] = (i <= int'(div_q));
        end
        // A load restarts the counter, so a tick on the loading edge would be a runt.
        raw_tick_s   = ((cnt_q & mask_s) == mask_s) && !bus.div_ld_i;
        step_rise_s  = bus.step_i && !step_prev_q;
        sw_rst_run_s = (state_q == ST_RUN) && bus.sw_rst_i;
        step_use_s   = (state_q == ST_RUN) && !bus.sw_rst_i && (bus.mode_i == MODE_STEP)
                       && raw_tick_s && step_pend_q;
        if (bus.div_sel_i > DIV_MAX) begin
            div_clamp_s = DIV_MAX;
        end else begin
            div_clamp_s = bus.div_sel_i;
        end
        if (sw_rst_run_s || (bus.mode_i != MODE_STEP) || step_use_s) begin
            step_pend_d = 1'b0;
        end else if (step_rise_s) begin
            step_pend_d = 1'b1;
        end else begin
            step_pend_d = step_pend_q;
        end
    end

    // Divider, reset sequencer FSM and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q     <= ST_ASSERT;
            cnt_q       <= '0;
            div_q       <= DIV_RST;
            rst_cnt_q   <= '0;
            step_prev_q <= 1'b0;
            step_pend_q <= 1'b0;
            tick_q      <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            rst_done_q  <= 1'b0;
            hb_q        <= 1'b0;
        end else begin
            if (bus.div_ld_i) begin
                cnt_q <= '0;
                div_q <= div_clamp_s;
            end else begin
                cnt_q <= cnt_q + CNT_ONE;
            end
            step_prev_q <= bus.step_i;
            step_pend_q <= step_pend_d;
            hb_q        <= cnt_q[HB_BIT];
            // Reset release trails the final reset tick by one clk so the core sees all of them.
            cpu_rst_n_q <= (state_q == ST_RUN);
            rst_done_q  <= (state_q == ST_RUN);
            case (state_q)
                ST_ASSERT: begin
                    tick_q <= raw_tick_s;
                    if (raw_tick_s) begin
                        if (rst_cnt_q == RST_LAST) begin
                            state_q   <= ST_RUN;
                            rst_cnt_q <= '0;
                        end else begin
                            rst_cnt_q <= rst_cnt_q + RCNT_ONE;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.sw_rst_i) begin
                        state_q   <= ST_ASSERT;
                        rst_cnt_q <= '0;
                        tick_q    <= 1'b0;
                    end else begin
                        case (bus.mode_i)
                            MODE_RUN:  tick_q <= raw_tick_s;
                            MODE_STEP: tick_q <= step_use_s;
                            default:   tick_q <= 1'b0;
                        endcase
                    end
                end
                default: begin
                    state_q   <= ST_ASSERT;
                    rst_cnt_q <= '0;
                    tick_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cpu_tick_o  = tick_q;
    assign bus.cpu_rst_no  = cpu_rst_n_q;
    assign bus.rst_done_o  = rst_done_q;
    assign bus.heartbeat_o = hb_q;

endmodule

// File: tb/tb_cpu_clk_rst_ctrl.sv
// Scoreboard bench: stimulus queues the expected tick cycles and reset level,
// a negedge monitor matches every cpu_tick_o pulse against that queue.
module tb_cpu_clk_rst_ctrl;

    typedef struct {
        int   cyc;
        logic rst_n;
    } exp_t;

    logic clk;
    logic reset_i;
    int   cyc;
    int   n_chk;
    int   n_err;
    exp_t exp_q[$];
    exp_t mon_e;

    cpu_clk_rst_ctrl_if bus();

    cpu_clk_rst_ctrl #(
        .CNT_WIDTH  (25),
        .DIV_DEFAULT(2),
        .RST_TICKS  (4),
        .HB_BIT     (3)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset_i),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #20000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Monitor: flags expected ticks that never came, unexpected ticks and wrong reset level.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            n_chk++;
            n_err++;
            $display("FAIL missing_tick: no tick at cycle %0d (now %0d)", exp_q[0].cyc, cyc);
            void'(exp_q.pop_front());
        end
        if (bus.cpu_tick_o === 1'b1) begin
            n_chk++;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                mon_e = exp_q.pop_front();
                if (bus.cpu_rst_no !== mon_e.rst_n) begin
                    n_err++;
                    $display("FAIL tick_rst_level: cycle %0d cpu_rst_no=%b want %b",
                             cyc, bus.cpu_rst_no, mon_e.rst_n);
                end
            end else begin
                n_err++;
                $display("FAIL extra_tick: tick at cycle %0d, next expected %0d",
                         cyc, (exp_q.size() > 0) ? exp_q[0].cyc : -1);
            end
        end
    end

    task automatic at_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic act, input logic exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: cycle %0d got %b want %b", name, cyc, act, exp_v);
        end
    endtask

    task automatic push(input int c, input logic r);
        exp_t e;
        e.cyc   = c;
        e.rst_n = r;
        exp_q.push_back(e);
    endtask

    initial begin
        cyc            = 0;
        n_chk          = 0;
        n_err          = 0;
        reset_i        = 1'b0;
        bus.div_sel_i  = 5'd0;
        bus.div_ld_i   = 1'b0;
        bus.mode_i     = 2'b00;
        bus.step_i     = 1'b0;
        bus.sw_rst_i   = 1'b0;

        // Reset values, then release: 8-clk grid, ticks on cycles 11,19,27,35 under reset.
        at_cyc(2);
        chk("rst_tick", bus.cpu_tick_o, 1'b0);
        chk("rst_rst_n", bus.cpu_rst_no, 1'b0);
        chk("rst_done", bus.rst_done_o, 1'b0);
        chk("rst_hb", bus.heartbeat_o, 1'b0);
        for (int i = 0; i < 4; i++) push(11 + 8 * i, 1'b0);
        for (int i = 0; i < 3; i++) push(43 + 8 * i, 1'b1);
        at_cyc(3);
        reset_i = 1'b1;
        at_cyc(15);
        chk("hb_high", bus.heartbeat_o, 1'b1);
        at_cyc(20);
        chk("hb_low", bus.heartbeat_o, 1'b0);
        at_cyc(35);
        chk("rst_n_at_4th_tick", bus.cpu_rst_no, 1'b0);
        at_cyc(36);
        chk("rst_n_released", bus.cpu_rst_no, 1'b1);
        chk("done_released", bus.rst_done_o, 1'b1);

        // Halt 100 clk, resume on the original grid.
        at_cyc(60);
        bus.mode_i = 2'b01;
        for (int i = 0; i < 3; i++) push(163 + 8 * i, 1'b1);
        at_cyc(160);
        bus.mode_i = 2'b00;

        // Single-step: three spaced edges then one long level.
        at_cyc(180);
        bus.mode_i = 2'b10;
        push(195, 1'b1);
        push(219, 1'b1);
        push(235, 1'b1);
        push(259, 1'b1);
        for (int i = 0; i < 3; i++) begin
            at_cyc(190 + 20 * i);
            bus.step_i = 1'b1;
            at_cyc(192 + 20 * i);
            bus.step_i = 1'b0;
        end
        at_cyc(250);
        bus.step_i = 1'b1;
        at_cyc(300);
        bus.step_i = 1'b0;
        bus.mode_i = 2'b00;
        push(307, 1'b1);

        // Divider load to 0 on a grid edge: that tick is dropped, then every 2 clk.
        for (int i = 0; i < 4; i++) push(317 + 2 * i, 1'b1);
        at_cyc(314);
        bus.div_sel_i = 5'd0;
        bus.div_ld_i  = 1'b1;
        at_cyc(315);
        bus.div_ld_i  = 1'b0;
        at_cyc(324);
        bus.mode_i = 2'b01;

        // Oversized exponent clamps to the counter width: no ticks for a long stretch.
        at_cyc(330);
        bus.mode_i    = 2'b00;
        bus.div_sel_i = 5'd31;
        bus.div_ld_i  = 1'b1;
        at_cyc(331);
        bus.div_ld_i  = 1'b0;

        // Back to exponent 2, then software reset on a raw-tick edge.
        for (int i = 0; i < 3; i++) push(409 + 8 * i, 1'b1);
        for (int i = 0; i < 4; i++) push(441 + 8 * i, 1'b0);
        at_cyc(400);
        bus.div_sel_i = 5'd2;
        bus.div_ld_i  = 1'b1;
        at_cyc(401);
        bus.div_ld_i  = 1'b0;
        at_cyc(432);
        bus.sw_rst_i = 1'b1;
        at_cyc(433);
        bus.sw_rst_i = 1'b0;
        chk("swrst_rst_n_same_edge", bus.cpu_rst_no, 1'b1);
        at_cyc(434);
        chk("swrst_rst_n_low", bus.cpu_rst_no, 1'b0);
        chk("swrst_done_low", bus.rst_done_o, 1'b0);
        at_cyc(466);
        chk("swrst_rst_n_release", bus.cpu_rst_no, 1'b1);
        chk("swrst_done_release", bus.rst_done_o, 1'b1);

        // Exponent 3, re-reset, hard reset after two reset ticks.
        push(485, 1'b0);
        push(501, 1'b0);
        at_cyc(468);
        bus.div_sel_i = 5'd3;
        bus.div_ld_i  = 1'b1;
        at_cyc(469);
        bus.div_ld_i  = 1'b0;
        at_cyc(480);
        bus.sw_rst_i = 1'b1;
        at_cyc(481);
        bus.sw_rst_i = 1'b0;
        at_cyc(482);
        chk("resw_rst_n_low", bus.cpu_rst_no, 1'b0);
        at_cyc(504);
        reset_i = 1'b0;
        at_cyc(505);
        reset_i = 1'b1;
        chk("hard_rst_tick", bus.cpu_tick_o, 1'b0);
        chk("hard_rst_rst_n", bus.cpu_rst_no, 1'b0);
        chk("hard_rst_done", bus.rst_done_o, 1'b0);
        chk("hard_rst_hb", bus.heartbeat_o, 1'b0);

        // Halted mode still lets reset ticks through on the default 8-clk grid.
        bus.mode_i = 2'b01;
        for (int i = 0; i < 4; i++) push(513 + 8 * i, 1'b0);
        at_cyc(537);
        chk("hard_rst_n_4th", bus.cpu_rst_no, 1'b0);
        at_cyc(538);
        chk("hard_rst_n_release", bus.cpu_rst_no, 1'b1);
        chk("hard_done_release", bus.rst_done_o, 1'b1);

        at_cyc(580);
        while (exp_q.size() > 0) begin
            n_chk++;
            n_err++;
            $display("FAIL missing_tick_end: no tick at cycle %0d", exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
